// File: rtl/decode_exec_pipe.sv
// decode_exec_pipe: decode-to-execute pipeline register with valid/ready handshake, flush and optional skid buffer (DEPIPE_SKID_EN)
module decode_exec_pipe #(
  parameter int DATA_W     = 24,
  parameter int REG_ADDR_W = 4,
  parameter int ALU_CTRL_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     rd1,
  input  logic [DATA_W-1:0]     rd2,
  input  logic [DATA_W-1:0]     extend,
  input  logic [REG_ADDR_W-1:0] ra3,
  input  logic [4:0]            ctrl,
  input  logic [ALU_CTRL_W-1:0] aluControl,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [DATA_W-1:0]     SrcA,
  output logic [DATA_W-1:0]     SrcB,
  output logic [DATA_W-1:0]     ExtImm,
  output logic [REG_ADDR_W-1:0] WA3E,
  output logic [4:0]            ctrlE,
  output logic [ALU_CTRL_W-1:0] aluControlE
);
  localparam int DW = 3 * DATA_W + REG_ADDR_W + ALU_CTRL_W;
  logic [DW-1:0] in_d;
  logic [DW-1:0] m_d;
  logic [4:0]    m_c;
  logic          m_v;
  logic          in_xfer;
  assign in_d     = {rd1, rd2, extend, ra3, aluControl};
  assign {SrcA, SrcB, ExtImm, WA3E, aluControlE} = m_d;
  assign ctrlE    = m_c;
  assign outValid = m_v;
  assign in_xfer  = inValid & inReady;
`ifdef DEPIPE_SKID_EN
  logic [DW-1:0] s_d;
  logic [4:0]    s_c;
  logic          s_v;
  assign inReady = ~s_v;
  // main register refills from skid first, then from the input; skid catches an input while main is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_v <= 1'b0;
      m_c <= '0;
      m_d <= '0;
      s_v <= 1'b0;
      s_c <= '0;
      s_d <= '0;
    end else if (flush) begin
      m_v <= 1'b0;
      m_c <= '0;
      s_v <= 1'b0;
      s_c <= '0;
    end else if (!m_v || outReady) begin
      if (s_v) begin
        m_v <= 1'b1;
        m_c <= s_c;
        m_d <= s_d;
        s_v <= 1'b0;
        s_c <= '0;
      end else if (in_xfer) begin
        m_v <= 1'b1;
        m_c <= ctrl;
        m_d <= in_d;
      end else begin
        m_v <= 1'b0;
        m_c <= '0;
      end
    end else if (in_xfer) begin
      s_v <= 1'b1;
      s_c <= ctrl;
      s_d <= in_d;
    end
  end
`else
  assign inReady = ~m_v | outReady;
  // single register: load on input transfer, empty on consume; ctrl cleared whenever the entry leaves
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_v <= 1'b0;
      m_c <= '0;
      m_d <= '0;
    end else if (flush) begin
      m_v <= 1'b0;
      m_c <= '0;
    end else if (in_xfer) begin
      m_v <= 1'b1;
      m_c <= ctrl;
      m_d <= in_d;
    end else if (outReady) begin
      m_v <= 1'b0;
      m_c <= '0;
    end
  end
`endif
endmodule

// File: tb/tb_decode_exec_pipe.sv
// tb_decode_exec_pipe: directed self-checking bench for decode_exec_pipe (default and wide parameter sets)
module tb_decode_exec_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic        flush = 1'b0;
  logic [23:0] rd1 = '0;
  logic [23:0] rd2 = '0;
  logic [23:0] extend = '0;
  logic [3:0]  ra3 = '0;
  logic [4:0]  ctrl = '0;
  logic [1:0]  aluControl = '0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [23:0] SrcA;
  logic [23:0] SrcB;
  logic [23:0] ExtImm;
  logic [3:0]  WA3E;
  logic [4:0]  ctrlE;
  logic [1:0]  aluControlE;
  logic        w_inValid = 1'b0;
  logic        w_inReady;
  logic [31:0] w_rd2 = '0;
  logic [4:0]  w_ra3 = '0;
  logic [2:0]  w_alu = '0;
  logic        w_outValid;
  logic [31:0] w_SrcA;
  logic [31:0] w_SrcB;
  logic [31:0] w_ExtImm;
  logic [4:0]  w_WA3E;
  logic [4:0]  w_ctrlE;
  logic [2:0]  w_aluE;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decode_exec_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady), .flush(flush),
    .rd1(rd1), .rd2(rd2), .extend(extend), .ra3(ra3), .ctrl(ctrl), .aluControl(aluControl),
    .outValid(outValid), .outReady(outReady), .SrcA(SrcA), .SrcB(SrcB), .ExtImm(ExtImm),
    .WA3E(WA3E), .ctrlE(ctrlE), .aluControlE(aluControlE)
  );

  decode_exec_pipe #(.DATA_W(32), .REG_ADDR_W(5), .ALU_CTRL_W(3)) u_wide (
    .clk(clk), .rst_n(rst_n), .inValid(w_inValid), .inReady(w_inReady), .flush(1'b0),
    .rd1(32'h0), .rd2(w_rd2), .extend(32'h0), .ra3(w_ra3), .ctrl(5'b10000), .aluControl(w_alu),
    .outValid(w_outValid), .outReady(1'b1), .SrcA(w_SrcA), .SrcB(w_SrcB), .ExtImm(w_ExtImm),
    .WA3E(w_WA3E), .ctrlE(w_ctrlE), .aluControlE(w_aluE)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid got %b want 0", outValid); end
    checks++; if (ctrlE !== 5'b0) begin errors++; $display("FAIL reset_ctrlE got %h want 00", ctrlE); end
    checks++; if ({SrcA, SrcB, ExtImm} !== 72'h0) begin errors++; $display("FAIL reset_data got %h want 0", {SrcA, SrcB, ExtImm}); end
    checks++; if ({WA3E, aluControlE} !== 6'h0) begin errors++; $display("FAIL reset_addr got %h want 0", {WA3E, aluControlE}); end
    checks++; if (w_SrcB !== 32'h0) begin errors++; $display("FAIL reset_wide_SrcB got %h want 0", w_SrcB); end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset_midstream();
    outReady = 1'b0;
    inValid = 1'b1; rd1 = 24'h000011; ctrl = 5'h1F;
    cyc();
    rd1 = 24'h000022; ctrl = 5'h1E;
    cyc();
    inValid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL rstmid_outValid got %b want 0", outValid); end
    checks++; if (ctrlE !== 5'b0) begin errors++; $display("FAIL rstmid_ctrlE got %h want 00", ctrlE); end
    cyc();
    rst_n = 1'b1;
    inValid = 1'b1; rd1 = 24'h000123; ctrl = 5'h03; outReady = 1'b1;
    cyc();
    inValid = 1'b0;
    checks++; if (outValid !== 1'b1 || SrcA !== 24'h000123) begin errors++; $display("FAIL rstmid_first got v=%b %h want v=1 000123", outValid, SrcA); end
    checks++; if (ctrlE !== 5'h03) begin errors++; $display("FAIL rstmid_ctrl got %h want 03", ctrlE); end
  endtask

  task automatic test_stream();
    outReady = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      inValid = 1'b1; rd1 = 24'(i); ctrl = 5'(i);
      cyc();
      checks++; if (outValid !== 1'b1 || SrcA !== 24'(i) || ctrlE !== 5'(i)) begin errors++; $display("FAIL stream_%0d got v=%b a=%h c=%h want v=1 a=%h c=%h", i, outValid, SrcA, ctrlE, 24'(i), 5'(i)); end
    end
    inValid = 1'b0;
    cyc();
    checks++; if (outValid !== 1'b0 || ctrlE !== 5'b0) begin errors++; $display("FAIL stream_drain got v=%b c=%h want v=0 c=00", outValid, ctrlE); end
  endtask

  task automatic test_stall();
    outReady = 1'b0;
    inValid = 1'b1; rd1 = 24'hAAAAAA; ctrl = 5'h10;
    cyc();
    checks++; if (outValid !== 1'b1 || SrcA !== 24'hAAAAAA) begin errors++; $display("FAIL stall_A got v=%b %h want v=1 AAAAAA", outValid, SrcA); end
    rd1 = 24'hBBBBBB; ctrl = 5'h08;
    #1;
`ifdef DEPIPE_SKID_EN
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL stall_ready_pre got %b want 1", inReady); end
`else
    checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL stall_ready_pre got %b want 0", inReady); end
`endif
    cyc();
    checks++; if (inReady !== 1'b0 || SrcA !== 24'hAAAAAA || ctrlE !== 5'h10) begin errors++; $display("FAIL stall_hold1 got r=%b %h c=%h want r=0 AAAAAA c=10", inReady, SrcA, ctrlE); end
`ifdef DEPIPE_SKID_EN
    inValid = 1'b0;
`endif
    cyc();
    checks++; if (outValid !== 1'b1 || SrcA !== 24'hAAAAAA) begin errors++; $display("FAIL stall_hold2 got v=%b %h want v=1 AAAAAA", outValid, SrcA); end
    outReady = 1'b1;
    cyc();
    inValid = 1'b0;
    checks++; if (outValid !== 1'b1 || SrcA !== 24'hBBBBBB || ctrlE !== 5'h08) begin errors++; $display("FAIL stall_B got v=%b %h c=%h want v=1 BBBBBB c=08", outValid, SrcA, ctrlE); end
    cyc();
    checks++; if (outValid !== 1'b0 || inReady !== 1'b1) begin errors++; $display("FAIL stall_empty got v=%b r=%b want v=0 r=1", outValid, inReady); end
  endtask

  task automatic test_flush();
    outReady = 1'b1;
    inValid = 1'b1; rd1 = 24'h00DEAD; ctrl = 5'b10000; flush = 1'b1;
    cyc();
    flush = 1'b0; inValid = 1'b0;
    checks++; if (outValid !== 1'b0 || ctrlE !== 5'b0 || inReady !== 1'b1) begin errors++; $display("FAIL flush_in got v=%b c=%h r=%b want v=0 c=00 r=1", outValid, ctrlE, inReady); end
    cyc();
    checks++; if (outValid !== 1'b0 || SrcA === 24'h00DEAD) begin errors++; $display("FAIL flush_dropped got v=%b %h want v=0 not 00DEAD", outValid, SrcA); end
    outReady = 1'b0;
    inValid = 1'b1; rd1 = 24'h000777; ctrl = 5'b11111;
    cyc();
    inValid = 1'b0; flush = 1'b1;
    cyc();
    flush = 1'b0;
    checks++; if (outValid !== 1'b0 || ctrlE !== 5'b0 || inReady !== 1'b1) begin errors++; $display("FAIL flush_held got v=%b c=%h r=%b want v=0 c=00 r=1", outValid, ctrlE, inReady); end
    checks++; if (SrcA !== 24'h000777) begin errors++; $display("FAIL flush_data_keep got %h want 000777", SrcA); end
    outReady = 1'b1;
  endtask

  task automatic test_param();
    w_inValid = 1'b1; w_rd2 = 32'hFFFF_FFFF; w_ra3 = 5'd31; w_alu = 3'd5;
    cyc();
    w_inValid = 1'b0;
    checks++; if (w_outValid !== 1'b1 || w_SrcB !== 32'hFFFF_FFFF) begin errors++; $display("FAIL param_SrcB got v=%b %h want v=1 FFFFFFFF", w_outValid, w_SrcB); end
    checks++; if (w_WA3E !== 5'd31 || w_aluE !== 3'd5 || w_ctrlE !== 5'b10000) begin errors++; $display("FAIL param_fields got wa=%0d alu=%0d c=%h want wa=31 alu=5 c=10", w_WA3E, w_aluE, w_ctrlE); end
    cyc();
    checks++; if (w_outValid !== 1'b0 || w_ctrlE !== 5'b0) begin errors++; $display("FAIL param_drain got v=%b c=%h want v=0 c=00", w_outValid, w_ctrlE); end
  endtask

  initial begin
    test_reset();
    test_reset_midstream();
    test_stream();
    test_stall();
    test_flush();
    test_param();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
